// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver frame sequencer.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      CHECK  = 3'd5
   } rx_state_t;

   localparam int         UART_DATA_BITS = 8;
   localparam logic [3:0] BIT_START      = 4'd0;
   localparam logic [3:0] BIT_LAST_DATA  = 4'(UART_DATA_BITS);

   // First oversample index at which the majority-sampled bit is stable.
   function automatic logic [5:0] chk_edge(input logic [5:0] prescale);
      return (prescale >> 1) + 6'd2;
   endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversample edge counter and frame bit counter for the UART receiver.
module uart_rx_edge_bit_cnt
   import uart_rx_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       cnt_en,
   input  logic       clr,
   input  logic [5:0] prescale,
   output logic [5:0] edge_cnt,
   output logic [3:0] bit_cnt
);

   logic [5:0] r_edge_cnt;
   logic [3:0] r_bit_cnt;
   logic [5:0] w_last_edge;

   assign w_last_edge = prescale - 6'd1;

   // Clear has priority so the sequencer can abort or finish a frame in any cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_edge_cnt <= '0;
         r_bit_cnt  <= BIT_START;
      end else if (clr) begin
         r_edge_cnt <= '0;
         r_bit_cnt  <= BIT_START;
      end else if (cnt_en) begin
         if (r_edge_cnt == w_last_edge) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= r_bit_cnt + 4'd1;
         end else begin
            r_edge_cnt <= r_edge_cnt + 6'd1;
         end
      end
   end

   assign edge_cnt = r_edge_cnt;
   assign bit_cnt  = r_bit_cnt;

endmodule

// File: rtl/uart_rx_fsm.sv
// UART RX frame sequencer: start detect, counter control, checker strobes, frame verdict.
// Optional parity support is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_fsm
   import uart_rx_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_in,
   input  logic       par_en,
   input  logic [5:0] prescale,
   input  logic       strt_glitch,
   input  logic       par_err,
   input  logic       stp_glitch,
   output logic [5:0] edge_cnt,
   output logic [3:0] bit_cnt,
   output logic       data_samp_en,
   output logic       deser_en,
   output logic       strt_chk_en,
   output logic       par_chk_en,
   output logic       stp_chk_en,
   output logic       data_valid,
   output logic       framing_err
);

   rx_state_t  r_state;
   logic       r_data_samp_en;
   logic       r_deser_en;
   logic       r_strt_chk_en;
   logic       r_stp_chk_en;
   logic       r_data_valid;
   logic       r_framing_err;

   logic       w_cnt_en;
   logic       w_clr;
   logic       w_edge_last;
   logic       w_at_chk_pre;
   logic       w_frame_err;
   logic [5:0] w_edge_cnt;
   logic [3:0] w_bit_cnt;

   uart_rx_edge_bit_cnt u_cnt (
      .clk      (clk),
      .rst      (rst),
      .cnt_en   (w_cnt_en),
      .clr      (w_clr),
      .prescale (prescale),
      .edge_cnt (w_edge_cnt),
      .bit_cnt  (w_bit_cnt)
   );

   assign w_edge_last  = (w_edge_cnt == prescale - 6'd1);
   // Strobes are registered, so they are armed one edge before CHK to land on it.
   assign w_at_chk_pre = (w_edge_cnt == chk_edge(prescale) - 6'd1);

   assign w_cnt_en = ((r_state == START) || (r_state == DATA) ||
                      (r_state == PARITY) || (r_state == STOP)) &&
                     !((r_state == STOP) && w_edge_last);

   assign w_clr = (r_state == IDLE) || (r_state == CHECK) ||
                  ((r_state == START) && w_edge_last && strt_glitch);

`ifdef UART_RX_PARITY_EN
   logic r_par_q;
   logic r_par_chk_en;
   assign w_frame_err = stp_glitch | (r_par_q & par_err);
   assign par_chk_en  = r_par_chk_en;
`else
   logic w_unused_par;
   assign w_unused_par = par_en ^ par_err;
   assign w_frame_err  = stp_glitch;
   assign par_chk_en   = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= IDLE;
         r_data_samp_en <= 1'b0;
         r_deser_en     <= 1'b0;
         r_strt_chk_en  <= 1'b0;
         r_stp_chk_en   <= 1'b0;
         r_data_valid   <= 1'b0;
         r_framing_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_q        <= 1'b0;
         r_par_chk_en   <= 1'b0;
`endif
      end else begin
         r_deser_en    <= 1'b0;
         r_strt_chk_en <= 1'b0;
         r_stp_chk_en  <= 1'b0;
         r_data_valid  <= 1'b0;
         r_framing_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_chk_en  <= 1'b0;
`endif
         case (r_state)
            IDLE: begin
               if (!rx_in) begin
                  r_state        <= START;
                  r_data_samp_en <= 1'b1;
`ifdef UART_RX_PARITY_EN
                  r_par_q        <= par_en;
`endif
               end
            end
            START: begin
               r_strt_chk_en <= w_at_chk_pre;
               if (w_edge_last) begin
                  if (strt_glitch) begin
                     r_state        <= IDLE;
                     r_data_samp_en <= 1'b0;
                  end else begin
                     r_state <= DATA;
                  end
               end
            end
            DATA: begin
               r_deser_en <= w_at_chk_pre;
               if (w_edge_last && (w_bit_cnt == BIT_LAST_DATA)) begin
`ifdef UART_RX_PARITY_EN
                  r_state <= r_par_q ? PARITY : STOP;
`else
                  r_state <= STOP;
`endif
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               r_par_chk_en <= w_at_chk_pre;
               if (w_edge_last) begin
                  r_state <= STOP;
               end
            end
`endif
            STOP: begin
               r_stp_chk_en <= w_at_chk_pre;
               if (w_edge_last) begin
                  r_state        <= CHECK;
                  r_data_samp_en <= 1'b0;
               end
            end
            CHECK: begin
               r_data_valid  <= !w_frame_err;
               r_framing_err <= w_frame_err;
               r_state       <= IDLE;
            end
            default: begin
               r_state        <= IDLE;
               r_data_samp_en <= 1'b0;
            end
         endcase
      end
   end

   assign edge_cnt     = w_edge_cnt;
   assign bit_cnt      = w_bit_cnt;
   assign data_samp_en = r_data_samp_en;
   assign deser_en     = r_deser_en;
   assign strt_chk_en  = r_strt_chk_en;
   assign stp_chk_en   = r_stp_chk_en;
   assign data_valid   = r_data_valid;
   assign framing_err  = r_framing_err;

endmodule
